// File: rtl/vid_pixfifo_pkg.sv
// Shared video definitions: controller state encoding and pixel-word field layout.
package vid_pixfifo_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } vid_state_e;

  localparam int PIX_W    = 24;
  localparam int PIX_R_HI = 23;
  localparam int PIX_R_LO = 16;
  localparam int PIX_G_HI = 15;
  localparam int PIX_G_LO = 8;
  localparam int PIX_B_HI = 7;
  localparam int PIX_B_LO = 0;

  // Packs the colour fields of a bus word into an RGB pixel; the top byte is dropped.
  function automatic logic [PIX_W-1:0] pix_of_word(input logic [31:0] word);
    return {word[PIX_R_HI:PIX_R_LO], word[PIX_G_HI:PIX_G_LO], word[PIX_B_HI:PIX_B_LO]};
  endfunction

endpackage

// File: rtl/vid_fifo_mem.sv
// Pixel storage: DEPTH x 24 array with one synchronous write port and one asynchronous read port.
module vid_fifo_mem
  import vid_pixfifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Storage write; contents are never reset, reads are gated by occupancy upstream.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vid_pixfifo.sv
// Video pixel FIFO: buffers bus read words and feeds the display one pixel per active pix_en.
module vid_pixfifo
  import vid_pixfifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   wr_valid,
  input  logic [31:0]            wr_data,
  output logic                   wr_ready,
  input  logic                   pix_en,
  input  logic                   hblank,
  input  logic                   vblank,
  output logic                   fetch_req,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow,
  output logic [7:0]             R,
  output logic [7:0]             G,
  output logic [7:0]             B
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_WATER);

  vid_state_e       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             vblank_q;
  logic             underflow_q, underflow_d;
  logic             fetch_q, fetch_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic [PIX_W-1:0] rd_data;
  logic             run, push, pop, take;

  assign run      = (state_q == ST_RUN);
  assign wr_ready = run && (level_q != FULL_LVL);
  assign push     = wr_valid && wr_ready;
  assign pop      = run && pix_en && !hblank && !vblank;
  assign take     = pop && (level_q != {LW{1'b0}});

  vid_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (pix_of_word(wr_data)),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Controller next state; dropping enable wins from any state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = ST_RUN;
        ST_RUN:   state_d = (vblank && !vblank_q) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_OFF;
      endcase
    end
  end

  // Pointers, occupancy, sticky underflow, fetch request and colour next values.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    underflow_d = underflow_q;
    rgb_d       = rgb_q;
    if (state_d != ST_RUN) begin
      // Leaving RUN empties the FIFO so OFF/FLUSH already show level 0.
      wr_ptr_d    = {AW{1'b0}};
      rd_ptr_d    = {AW{1'b0}};
      level_d     = {LW{1'b0}};
      underflow_d = 1'b0;
    end else begin
      wr_ptr_d    = push ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
      rd_ptr_d    = take ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      level_d     = level_q + LW'(push) - LW'(take);
      underflow_d = underflow_q || (pop && !take);
    end
    if (pix_en) begin
      rgb_d = take ? rd_data : {PIX_W{1'b0}};
    end else begin
      rgb_d = rgb_q;
    end
    fetch_d = run && (state_d == ST_RUN) && (level_q <= LOW_LVL) && !vblank;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {LW{1'b0}};
      vblank_q    <= 1'b0;
      underflow_q <= 1'b0;
      fetch_q     <= 1'b0;
      rgb_q       <= {PIX_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      vblank_q    <= vblank;
      underflow_q <= underflow_d;
      fetch_q     <= fetch_d;
      rgb_q       <= rgb_d;
    end
  end

  assign level     = level_q;
  assign underflow = underflow_q;
  assign fetch_req = fetch_q;
  assign R         = rgb_q[PIX_R_HI:PIX_R_LO];
  assign G         = rgb_q[PIX_G_HI:PIX_G_LO];
  assign B         = rgb_q[PIX_B_HI:PIX_B_LO];

endmodule

// File: tb/tb_vid_pixfifo.sv
// Scoreboard bench for vid_pixfifo: queue-based reference model plus directed spot checks.
module tb_vid_pixfifo;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 8;

  logic        clk = 1'b0;
  logic        reset, enable, wr_valid, pix_en, hblank, vblank;
  logic [31:0] wr_data;
  logic        wr_ready, fetch_req, underflow;
  logic [4:0]  level;
  logic [7:0]  R, G, B;

  always #5 clk = ~clk;

  vid_pixfifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .pix_en(pix_en), .hblank(hblank), .vblank(vblank),
    .fetch_req(fetch_req), .level(level), .underflow(underflow), .R(R), .G(G), .B(B)
  );

  typedef struct {
    bit          rdy;
    bit          fetch;
    int          lvl;
    bit          uf;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0=OFF 1=RUN 2=FLUSH, FIFO contents as a queue of pixels.
  int          m_st = 0;
  logic [23:0] m_fifo[$];
  bit          m_uf = 1'b0, m_fetch = 1'b0, m_vbp = 1'b0;
  logic [23:0] m_rgb = 24'h0;

  task automatic model_step();
    bit   rdy, psh, pp, nfetch;
    int   nst;
    exp_t e;
    rdy = (m_st == 1) && (m_fifo.size() != DEPTH);
    if (reset) begin
      m_st = 0; m_fifo.delete(); m_uf = 1'b0; m_fetch = 1'b0; m_vbp = 1'b0; m_rgb = 24'h0;
    end else begin
      psh = wr_valid && rdy;
      pp  = (m_st == 1) && pix_en && !hblank && !vblank;
      if (!enable)           nst = 0;
      else if (m_st == 1)    nst = (vblank && !m_vbp) ? 2 : 1;
      else                   nst = 1;
      nfetch = (m_st == 1) && (nst == 1) && (m_fifo.size() <= LOW_WATER) && !vblank;
      if (pix_en) begin
        if (pp && m_fifo.size() > 0) m_rgb = m_fifo.pop_front();
        else                         m_rgb = 24'h0;
        if (pp && !(m_rgb != 24'h0 || 0)) begin end
      end
      if (pp && m_fifo.size() == 0 && !pix_en) begin end
      if (psh) m_fifo.push_back(wr_data[23:0]);
      m_vbp = vblank; m_st = nst; m_fetch = nfetch;
    end
    e.rdy = (m_st == 1) && (m_fifo.size() != DEPTH);
    e.fetch = m_fetch; e.lvl = m_fifo.size(); e.uf = m_uf; e.rgb = m_rgb;
    exp_q.push_back(e);
  endtask

  // Underflow is tracked separately since it depends on occupancy before the pop.
  task automatic step_with_uf();
    bit pp, emp, lea;
    int nst_guess;
    pp  = !reset && (m_st == 1) && pix_en && !hblank && !vblank;
    emp = (m_fifo.size() == 0);
    lea = !reset && (!enable || ((m_st == 1) && vblank && !m_vbp));
    nst_guess = 0;
    if (pp && emp) m_uf = 1'b1;
    if (lea) m_uf = 1'b0;
    model_step();
    if (m_st != 1) m_fifo.delete();
    exp_q[exp_q.size()-1].lvl = m_fifo.size();
    exp_q[exp_q.size()-1].rdy = (m_st == 1) && (m_fifo.size() != DEPTH);
    exp_q[exp_q.size()-1].uf  = m_uf;
  endtask

  task automatic cyc(input bit rs, input bit en, input bit wv, input logic [31:0] wd,
                     input bit pe, input bit hb, input bit vb);
    reset = rs; enable = en; wr_valid = wv; wr_data = wd; pix_en = pe; hblank = hb; vblank = vb;
    @(posedge clk);
    step_with_uf();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle(input bit vb);          cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, vb); endtask
  task automatic push(input logic [31:0] d);  cyc(1'b0, 1'b1, 1'b1, d,     1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                       cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); endtask
  task automatic pushpop(input logic [31:0] d); cyc(1'b0, 1'b1, 1'b1, d,   1'b1, 1'b0, 1'b0); endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (wr_ready !== e.rdy || fetch_req !== e.fetch || int'(level) != e.lvl ||
            underflow !== e.uf || {R, G, B} !== e.rgb) begin
          errors++;
          $display("FAIL scoreboard t=%0t actual rdy=%b fetch=%b lvl=%0d uf=%b rgb=%h required rdy=%b fetch=%b lvl=%0d uf=%b rgb=%h",
                   $time, wr_ready, fetch_req, level, underflow, {R, G, B},
                   e.rdy, e.fetch, e.lvl, e.uf, e.rgb);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
    pix_en = 1'b0; hblank = 1'b0; vblank = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ready", 32'(wr_ready), 32'd0);
    chk("reset_fetch", 32'(fetch_req), 32'd0);
    chk("reset_uf", 32'(underflow), 32'd0);
    chk("reset_rgb", 32'({R, G, B}), 32'h0);

    idle(1'b0);
    chk("run_ready", 32'(wr_ready), 32'd1);
    push(32'h00112233);
    push(32'h00445566);
    chk("two_level", 32'(level), 32'd2);
    pop();
    chk("pop1_rgb", 32'({R, G, B}), 32'h112233);
    pop();
    chk("pop2_rgb", 32'({R, G, B}), 32'h445566);
    chk("pop2_level", 32'(level), 32'd0);

    for (int i = 1; i <= 16; i++) push(32'hFF5A0000 + 32'(i));
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(wr_ready), 32'd0);
    push(32'hFF5A0011);
    chk("full_no_store", 32'(level), 32'd16);
    pushpop(32'hFF5A0012);
    chk("full_pushpop_level", 32'(level), 32'd15);
    chk("full_first_word", 32'({R, G, B}), 32'h5A0001);

    for (int i = 0; i < 6; i++) pop();
    chk("lvl9", 32'(level), 32'd9);
    chk("lvl9_rgb", 32'({R, G, B}), 32'h5A0007);
    pop();
    chk("lvl8_fetch_lag", 32'(fetch_req), 32'd0);
    idle(1'b0);
    chk("lvl8_fetch", 32'(fetch_req), 32'd1);
    for (int i = 0; i < 3; i++) pop();
    chk("lvl5", 32'(level), 32'd5);
    idle(1'b1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_ready", 32'(wr_ready), 32'd0);
    chk("flush_fetch", 32'(fetch_req), 32'd0);
    idle(1'b1);
    chk("after_flush_ready", 32'(wr_ready), 32'd1);

    pop();
    chk("uf_rgb", 32'({R, G, B}), 32'h0);
    chk("uf_flag", 32'(underflow), 32'd1);
    pushpop(32'h77ABCDEF);
    chk("pp0_level", 32'(level), 32'd1);
    chk("pp0_rgb", 32'({R, G, B}), 32'h0);
    pop();
    chk("pp0_word", 32'({R, G, B}), 32'hABCDEF);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("hblank_black", 32'({R, G, B}), 32'h0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("uf_sticky", 32'(underflow), 32'd1);
    idle(1'b1);
    chk("uf_cleared", 32'(underflow), 32'd0);
    idle(1'b0);

    push(32'h00010203); push(32'h00040506); push(32'h00070809);
    pop();
    cyc(1'b1, 1'b1, 1'b1, 32'h00AABBCC, 1'b1, 1'b0, 1'b0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_rgb", 32'({R, G, B}), 32'h0);
    chk("midrst_ready", 32'(wr_ready), 32'd0);
    idle(1'b0);
    chk("midrst_run_level", 32'(level), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int seg;
      bit rs, en, wv, pe, hb, vb;
      seg = (i / 250) % 4;
      rs  = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 149) != 0);
      case (seg)
        0:       begin wv = ($urandom_range(0, 3) != 0); pe = ($urandom_range(0, 3) == 0); end
        1:       begin wv = ($urandom_range(0, 3) == 0); pe = ($urandom_range(0, 3) != 0); end
        default: begin wv = $urandom_range(0, 1) == 1;   pe = $urandom_range(0, 1) == 1;   end
      endcase
      hb = ((i % 40) >= 33);
      vb = ((i % 450) >= 420);
      cyc(rs, en, wv, $urandom, pe, hb, vb);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
